// File: rtl/accum_pkg.sv
// accum_pkg: shared bank state type and per-lane accumulate arithmetic for
// accum_pingpong_buffer.
// Build option: define ACCUM_SAT_EN for saturating lane adds; otherwise adds wrap.
package accum_pkg;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } bank_state_t;

  // Working width for lane arithmetic; accumulators up to SAT_W-1 bits fit
  // without the intermediate sum overflowing.
  localparam int unsigned SAT_W = 64;

  typedef struct packed {
    logic [SAT_W-1:0] sum;
    logic             sat;
  } sat_res_t;

  // Add two sign-extended operands and fold the result back into acc_w bits,
  // clamping to the signed acc_w range (and flagging it) when saturation is built in.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                       input logic signed [SAT_W-1:0] b,
                                       input int unsigned             acc_w);
    logic signed [SAT_W-1:0] s;
    sat_res_t                r;
    s     = a + b;
    r.sat = 1'b0;
`ifdef ACCUM_SAT_EN
    begin
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      max_v = (64'sd1 <<< (acc_w - 32'd1)) - 64'sd1;
      min_v = -max_v - 64'sd1;
      if (s > max_v) begin
        r.sum = max_v;
        r.sat = 1'b1;
      end else if (s < min_v) begin
        r.sum = min_v;
        r.sat = 1'b1;
      end else begin
        r.sum = s;
      end
    end
`else
    r.sum = (s <<< (SAT_W - acc_w)) >>> (SAT_W - acc_w);
`endif
    return r;
  endfunction

endpackage

// File: rtl/accum_lane.sv
// accum_lane: one lane of the row update -- sign-extends the incoming partial
// sum and either overwrites or accumulates onto the stored value.
// Build option: ACCUM_SAT_EN (via accum_pkg::sat_add) makes the add saturate.
module accum_lane
  import accum_pkg::*;
#(
  parameter int unsigned IN_W  = 24,
  parameter int unsigned ACC_W = 32   // must satisfy IN_W <= ACC_W < SAT_W
) (
  input  logic [ACC_W-1:0] i_old,
  input  logic [IN_W-1:0]  i_in,
  input  logic             i_first,
  output logic [ACC_W-1:0] o_next,
  output logic             o_sat
);

  logic signed [ACC_W-1:0] w_in_ext;
  sat_res_t                w_res;
  logic                    w_unused_hi;

  assign w_in_ext    = ACC_W'($signed(i_in));
  assign w_res       = sat_add(SAT_W'($signed(i_old)), SAT_W'(w_in_ext), ACC_W);
  assign w_unused_hi = ^w_res.sum[SAT_W-1:ACC_W];

  // Pick overwrite (first beat of the row) or the accumulated sum
  always_comb begin
    o_next = w_res.sum[ACC_W-1:0];
    o_sat  = 1'b0;
    if (i_first) begin
      o_next = w_in_ext;
      o_sat  = 1'b0;
    end else begin
      o_next = w_res.sum[ACC_W-1:0];
      o_sat  = w_res.sat;
    end
  end

endmodule

// File: rtl/accum_pingpong_buffer.sv
// accum_pingpong_buffer: two-bank accumulation buffer. The write bank gathers
// row-indexed partial sums from the array; the other bank drains finished
// tiles row by row over valid/ready.
// Build option: ACCUM_SAT_EN enables saturating adds and the per-bank out_sat flag.
module accum_pingpong_buffer
  import accum_pkg::*;
#(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 16,
  parameter int unsigned IN_W  = 24,
  parameter int unsigned ACC_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     psum_valid,
  output logic                     in_ready,
  input  logic [$clog2(ROWS):0]    psum_row,
  input  logic                     psum_first,
  input  logic                     psum_last,
  input  logic [COLS*IN_W-1:0]     psum_data,
  output logic                     psum_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(ROWS)-1:0]  out_row,
  output logic                     out_last,
  output logic [COLS*ACC_W-1:0]    out_data,
  output logic                     out_sat
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned DW = COLS * ACC_W;
  localparam logic [RW:0] ROWS_L = (RW + 1)'(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  bank_state_t     r_state [2];
  logic            r_wr_bank;
  logic            r_rd_bank;
  logic [RW-1:0]   r_rd_row;
  logic [DW-1:0]   r_bank [2][ROWS];
  logic            r_err;

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_acc;
  logic            w_row_ok;
  logic            w_wr;
  logic            w_drain;
  logic            w_rd_end;
  logic [RW-1:0]   w_wr_idx;
  logic [DW-1:0]   w_row_old;
  logic [DW-1:0]   w_row_next;
  logic [COLS-1:0] w_lane_sat;

  assign w_in_ready  = (r_state[r_wr_bank] != FULL);
  assign w_out_valid = (r_state[r_rd_bank] == FULL);
  assign w_acc       = psum_valid && w_in_ready;
  assign w_row_ok    = (psum_row < ROWS_L);
  assign w_wr        = w_acc && w_row_ok;
  assign w_drain     = w_out_valid && out_ready;
  assign w_rd_end    = (r_rd_row == LAST_ROW);
  assign w_wr_idx    = psum_row[RW-1:0];
  // A FULL read bank is never the write target while it is FULL, so the
  // single read-modify-write port never collides with the drain read.
  assign w_row_old   = r_bank[r_wr_bank][w_wr_idx];

  for (genvar j = 0; j < COLS; j++) begin : g_lane
    accum_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .i_old   (w_row_old[j*ACC_W +: ACC_W]),
      .i_in    (psum_data[j*IN_W +: IN_W]),
      .i_first (psum_first),
      .o_next  (w_row_next[j*ACC_W +: ACC_W]),
      .o_sat   (w_lane_sat[j])
    );
  end

  // Row storage: commit the updated row for every accepted in-range beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < int'(ROWS); r++) begin
          r_bank[b][r] <= {DW{1'b0}};
        end
      end
    end else if (w_wr) begin
      r_bank[r_wr_bank][w_wr_idx] <= w_row_next;
    end
  end

  // Bank life cycle, ping-pong pointers, drain row counter and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state[0] <= FREE;
      r_state[1] <= FREE;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_rd_row   <= {RW{1'b0}};
      r_err      <= 1'b0;
    end else begin
      r_err <= w_acc && !w_row_ok;
      if (w_wr && (r_state[r_wr_bank] == FREE)) begin
        r_state[r_wr_bank] <= ACCUM;
      end
      // Close on last even for an out-of-range row so the tile still completes.
      if (w_acc && psum_last) begin
        r_state[r_wr_bank] <= FULL;
        r_wr_bank          <= ~r_wr_bank;
      end
      if (w_drain) begin
        if (w_rd_end) begin
          r_rd_row           <= {RW{1'b0}};
          r_state[r_rd_bank] <= FREE;
          r_rd_bank          <= ~r_rd_bank;
        end else begin
          r_rd_row <= r_rd_row + RW'(1);
        end
      end
    end
  end

`ifdef ACCUM_SAT_EN
  logic [1:0] r_sat;

  // Sticky per-bank clamp flag; a fresh tile starts with the first beat of row 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 2'b00;
    end else if (w_wr) begin
      if (psum_first && (w_wr_idx == {RW{1'b0}})) begin
        r_sat[r_wr_bank] <= 1'b0;
      end else if (|w_lane_sat) begin
        r_sat[r_wr_bank] <= 1'b1;
      end
    end
  end

  assign out_sat = w_out_valid && r_sat[r_rd_bank];
`else
  logic w_unused_sat;
  assign w_unused_sat = ^w_lane_sat;
  assign out_sat      = 1'b0;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_row   = r_rd_row;
  assign out_last  = w_out_valid && w_rd_end;
  assign out_data  = r_bank[r_rd_bank][r_rd_row];
  assign psum_err  = r_err;

endmodule

// File: tb/tb_accum_pingpong_buffer.sv
// Self-checking bench for accum_pingpong_buffer: tile-level model compared
// every cycle, plus literal expectations on drained rows.
module tb_accum_pingpong_buffer;

  localparam int ROWS  = 4;
  localparam int COLS  = 16;
  localparam int IN_W  = 24;
  localparam int ACC_W = 32;
  localparam int RW    = 2;
  localparam int DW    = COLS * ACC_W;
  localparam int PW    = COLS * IN_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          psum_valid = 1'b0;
  logic          psum_first = 1'b0;
  logic          psum_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [RW:0]   psum_row = '0;
  logic [PW-1:0] psum_data = '0;
  logic          in_ready, psum_err, out_valid, out_last, out_sat;
  logic [RW-1:0] out_row;
  logic [DW-1:0] out_data;

  accum_pingpong_buffer #(.ROWS(ROWS), .COLS(COLS), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .psum_valid(psum_valid), .in_ready(in_ready),
    .psum_row(psum_row), .psum_first(psum_first), .psum_last(psum_last),
    .psum_data(psum_data), .psum_err(psum_err), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_last(out_last),
    .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- tile-level model ----------------
  logic [ACC_W-1:0] mm [2][ROWS][COLS];  // contents of each physical bank
  int               fq[$];               // banks holding finished tiles, oldest first
  int               m_wb;                // bank the next beats go to
  int               m_rr;                // row of the oldest finished tile being drained
  bit               m_err;
  bit               m_sat [2];

  function automatic void m_clear();
    fq.delete();
    m_wb = 0; m_rr = 0; m_err = 0;
    m_sat[0] = 0; m_sat[1] = 0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < ROWS; r++)
        for (int j = 0; j < COLS; j++) mm[b][r][j] = '0;
  endfunction

  function automatic logic [ACC_W-1:0] m_add(input logic [ACC_W-1:0] a, input logic [IN_W-1:0] b,
                                             output bit clamped);
    longint sa, sb, s, mx, mn;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = sa + sb;
    mx = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    clamped = 0;
`ifdef ACCUM_SAT_EN
    if (s > mx) begin s = mx; clamped = 1; end
    else if (s < mn) begin s = mn; clamped = 1; end
`endif
    return s[ACC_W-1:0];
  endfunction

  always @(negedge rst_n) m_clear();

  always @(posedge clk) begin : model_step
    bit acc, drn, ok, cl, any;
    logic [IN_W-1:0] ln;
    if (rst_n) begin
      acc   = psum_valid && (fq.size() < 2);
      drn   = (fq.size() > 0) && out_ready;
      ok    = (int'(psum_row) < ROWS);
      m_err = acc && !ok;
      if (acc && ok) begin
        any = 0;
        for (int j = 0; j < COLS; j++) begin
          ln = psum_data[j*IN_W +: IN_W];
          if (psum_first) mm[m_wb][psum_row][j] = ACC_W'($signed(ln));
          else begin
            mm[m_wb][psum_row][j] = m_add(mm[m_wb][psum_row][j], ln, cl);
            any |= cl;
          end
        end
        if (psum_first && psum_row == 0) m_sat[m_wb] = 0;
        else if (any) m_sat[m_wb] = 1;
      end
      if (acc && psum_last) begin
        fq.push_back(m_wb);
        m_wb ^= 1;
      end
      if (drn) begin
        m_rr++;
        if (m_rr == ROWS) begin
          m_rr = 0;
          void'(fq.pop_front());
        end
      end
    end
  end

  typedef struct {
    int            row;
    bit            last;
    bit            sat;
    logic [DW-1:0] data;
  } drain_t;
  drain_t dq[$];

  // Compare process: DUT outputs against the model on every falling edge
  always @(negedge clk) begin : compare
    logic [DW-1:0] e;
    drain_t d;
    chk("in_ready", in_ready, fq.size() < 2);
    chk("out_valid", out_valid, fq.size() > 0);
    chk("psum_err", psum_err, m_err);
    if (psum_err) err_cnt++;
    if (fq.size() > 0) begin
      for (int j = 0; j < COLS; j++) e[j*ACC_W +: ACC_W] = mm[fq[0]][m_rr][j];
      chk("out_row", out_row, m_rr);
      chk("out_last", out_last, m_rr == ROWS - 1);
      chk("out_data", out_data, e);
      chk("out_sat", out_sat, m_sat[fq[0]]);
      if (out_valid && out_ready) begin
        d.row = out_row; d.last = out_last; d.sat = out_sat; d.data = out_data;
        dq.push_back(d);
      end
    end else begin
      chk("out_last_idle", out_last, 0);
      chk("out_sat_idle", out_sat, 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int row, input bit first, input bit last, input logic [PW-1:0] d);
    psum_valid = 1'b1; psum_row = row[RW:0]; psum_first = first; psum_last = last; psum_data = d;
    cyc();
    psum_valid = 1'b0; psum_first = 1'b0; psum_last = 1'b0;
  endtask

  function automatic logic [PW-1:0] vec(input int base, input int step);
    logic [PW-1:0] v;
    int x;
    for (int j = 0; j < COLS; j++) begin
      x = base + step * j;
      v[j*IN_W +: IN_W] = x[IN_W-1:0];
    end
    return v;
  endfunction

  function automatic logic [PW-1:0] one_lane(input int j, input int val);
    logic [PW-1:0] v;
    v = '0;
    v[j*IN_W +: IN_W] = val[IN_W-1:0];
    return v;
  endfunction

  function automatic logic [ACC_W-1:0] lane_of(input logic [DW-1:0] d, input int j);
    return d[j*ACC_W +: ACC_W];
  endfunction

  task automatic full_tile(input int base, input int step);
    for (int r = 0; r < ROWS; r++) beat(r, 1'b1, r == ROWS - 1, vec(base, step));
  endtask

  task automatic wait_dq(input int n);
    for (int i = 0; i < 300 && dq.size() < n; i++) cyc();
    chk("drain_timeout", dq.size() >= n, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [ACC_W-1:0] sat_exp;
    bit               sat_flag;
    m_clear();
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_psum_err", psum_err, 0);
    chk("rst_out_sat", out_sat, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // 1: first with lane index, two +1 adds per row, last on row 3
    out_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) beat(r, 1'b1, 1'b0, vec(0, 1));
    for (int r = 0; r < ROWS; r++) begin
      beat(r, 1'b0, 1'b0, vec(1, 0));
      beat(r, 1'b0, r == ROWS - 1, vec(1, 0));
    end
    wait_dq(4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_row", dq[i].row, i);
      chk("t1_last", dq[i].last, i == 3);
      chk("t1_lane0", lane_of(dq[i].data, 0), 32'd2);
      chk("t1_lane15", lane_of(dq[i].data, 15), 32'd17);
    end
    dq.delete();

    // 2: backpressure with two closed tiles, third tile ignored
    out_ready = 1'b0;
    full_tile(100, 1);
    full_tile(-1, -1);
    chk("t2_full_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) beat(0, 1'b1, 1'b0, vec(7, 0));
    out_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("t2_in_ready_3hs", in_ready, 0);
    cyc();
    chk("t2_in_ready_4hs", in_ready, 1);
    wait_dq(8);
    chk("t2_a_lane5", lane_of(dq[0].data, 5), 32'd105);
    chk("t2_b_lane3", lane_of(dq[4].data, 3), 32'hFFFFFFFC);
    chk("t2_b_last", dq[7].last, 1);
    dq.delete();

    // 3: out-of-range row pulses error without touching the bank
    err_cnt = 0;
    for (int r = 0; r < ROWS; r++) beat(r, 1'b1, 1'b0, vec(50, 2));
    beat(5, 1'b1, 1'b0, vec(999, 0));
    beat(3, 1'b0, 1'b1, vec(0, 0));
    wait_dq(4);
    chk("t3_err_pulses", err_cnt, 1);
    chk("t3_row1_lane2", lane_of(dq[1].data, 2), 32'd54);
    dq.delete();

    // 4: accumulate lane 0 to 0x7FFFFFF0, add 0x20; negative lane -5 on row 1
    beat(0, 1'b1, 1'b0, one_lane(0, 32'h0F0));
    for (int r = 1; r < ROWS; r++) beat(r, 1'b1, 1'b0, vec(0, 0));
    beat(1, 1'b0, 1'b0, one_lane(0, -5));
    for (int i = 0; i < 256; i++) beat(0, 1'b0, 1'b0, one_lane(0, 32'h7FFFFF));
    beat(0, 1'b0, 1'b1, one_lane(0, 32'h20));
    wait_dq(4);
`ifdef ACCUM_SAT_EN
    sat_exp = 32'h7FFFFFFF; sat_flag = 1'b1;
`else
    sat_exp = 32'h80000010; sat_flag = 1'b0;
`endif
    chk("t4_sat_lane", lane_of(dq[0].data, 0), sat_exp);
    chk("t4_sat_flag", dq[0].sat, sat_flag);
    chk("t4_sat_flag_r3", dq[3].sat, sat_flag);
    chk("t4_neg_lane", lane_of(dq[1].data, 0), 32'hFFFFFFFB);
    dq.delete();

    // 5: reset in the middle of a drain, then a fresh tile from row 0
    out_ready = 1'b0;
    full_tile(10, 1);
    out_ready = 1'b1;
    cyc(); cyc();
    chk("t5_row_before_rst", out_row, 2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_in_ready", in_ready, 1);
    chk("t5_rst_out_row", out_row, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    dq.delete();
    full_tile(20, 3);
    wait_dq(4);
    chk("t5_first_row", dq[0].row, 0);
    chk("t5_lane1", lane_of(dq[0].data, 1), 32'd23);
    chk("t5_last_row", dq[3].row, 3);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_pingpong_buffer.md
# accum_pingpong_buffer

Parametrised two-bank (ping-pong) accumulation buffer placed between the systolic array's PE-column outputs and the result writeback path. The array streams row-indexed partial-sum vectors into the write bank while the other bank drains finished tiles row by row over a valid/ready interface. Compared with the previous fixed 4x64 buffer, it adds:
- run-time first/last tile control
- explicit backpressure
- signed width extension
- optional saturation

## Interface
- ROWS, 4, rows per tile (bank depth)
- COLS, 16, lanes per row vector
- IN_W, 24, signed partial-sum width per lane
- ACC_W, 32, signed accumulator width per lane; ACC_W >= IN_W
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- psum_valid  in  1  input beat valid
- in_ready  out  1  write bank can accept beats
- psum_row  in  $clog2(ROWS)+1  target row index
- psum_first  in  1  overwrite row instead of add
- psum_last  in  1  last beat of tile; closes write bank
- psum_data  in  COLS*IN_W  lane j at bits [j*IN_W +: IN_W]
- psum_err  out  1  one-cycle pulse: accepted beat had psum_row >= ROWS
- out_valid  out  1  drain row valid
- out_ready  in  1  downstream accepts row
- out_row  out  $clog2(ROWS)  row index being drained
- out_last  out  1  high on row ROWS-1 of a tile
- out_data  out  COLS*ACC_W  drained row vector
- out_sat  out  1  tile contained a saturation event (see Configuration)

## Operation
- Each bank is in state FREE, ACCUM or FULL. wr_bank and rd_bank are 1-bit pointers.
- in_ready = (state[wr_bank] != FULL). Handshake beat = psum_valid && in_ready. Beats while in_ready=0 are ignored; no data loss is implied, because the sender must hold.
- Accepted beat with row < ROWS:
  - If psum_first: bank[wr_bank][row][j] <= sext(psum_data lane j).
  - Otherwise: bank[wr_bank][row][j] <= bank[wr_bank][row][j] + sext(lane j).
  - Bank state goes FREE->ACCUM.
- Accepted beat with row >= ROWS: no array write, psum_err=1 next cycle. psum_last on such a beat is still honoured.
- Accepted beat with psum_last: state[wr_bank] <= FULL, wr_bank toggles. A tile with only a last beat is legal.
- Drain: out_valid = (state[rd_bank]==FULL). out_data = bank[rd_bank][rd_row]; it stays stable while out_valid && !out_ready.
  - Each out handshake increments rd_row.
  - Handshake at row ROWS-1: rd_row <= 0, state[rd_bank] <= FREE, rd_bank toggles.
- Banks are never cleared; rows not written with psum_first since the last FREE hold stale data. Producer must issue psum_first per row per tile.
- Arithmetic: two's complement, ACC_W bits, lane-independent.

## Timing
- Reset values: in_ready=1, out_valid=0, out_row=0, out_last=0, psum_err=0, out_sat=0, out_data=X-free (bank 0 row 0 contents, unspecified), wr_bank=rd_bank=0, all banks FREE.
- Write latency: an accepted beat is visible in the array at the next edge. A closing psum_last makes out_valid rise 1 cycle after acceptance.
- FREE from drain completes at the edge; in_ready rises the following cycle. There is no combinational path from out_ready to in_ready.
- Simultaneous close of bank A and drain completion of bank B in the same cycle: both take effect. Pointers swap cleanly.
- Back-to-back beats to the same row accumulate every cycle (read-modify-write in one cycle; no hazard).
- Reset mid-tile: partial tile is discarded and the drain is aborted.

## Configuration
- ACCUM_SAT_EN defined:
  - Each lane add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - A per-bank sticky sat flag is set on any clamp and cleared on psum_first to row 0.
  - out_sat = flag of rd_bank while out_valid.
- Undefined: wraparound add, out_sat tied 0.

## Structure
- Package accum_pkg: bank_state_t enum (FREE, ACCUM, FULL) and function sat_add(a, b) gated by ACCUM_SAT_EN.
- Sub-module accum_lane: one lane holding the sign-extend, add/overwrite and optional saturate, instantiated COLS times. Its output is the next row value plus a sat bit.

## Test plan
- ROWS=4, COLS=16: rows 0..3 with first=1, data=lane index, then 2 add beats of +1, last on row 3 -> drained rows equal lane+2, out_last on row 3, out_row 0..3.
- Hold out_ready=0 while closing two tiles -> in_ready=0 after second close. Third-tile beats ignored. After 4 handshakes, in_ready=1 one cycle later.
- psum_row=5 with valid, in_ready=1 -> psum_err pulses once, bank contents unchanged.
- With ACCUM_SAT_EN, ACC_W=32: lane at 0x7FFFFFF0 plus 0x20 -> 0x7FFFFFFF, out_sat=1. Without the macro -> 0x80000010, out_sat=0.
- Negative input lane -0x5 (IN_W=24) added to 0 -> out lane 0xFFFFFFFB.
- Assert rst_n low mid-drain at row 2 -> out_valid=0 and in_ready=1 immediately. Next tile drains from bank 0 row 0.
